// File: rtl/operand_pair_fifo_if.sv
// Valid/ready bundle between the operand producer, the pair FIFO
// and the downstream two-operand consumer, plus FIFO status.
interface operand_pair_fifo_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
);
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [ADDR_W:0]  count;
  logic             overflow;
  logic [7:0]       pop_total;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b,
    input  count, overflow, pop_total
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b,
    output count, overflow, pop_total
  );
endinterface

// File: rtl/operand_pair_fifo.sv
// First-word-fall-through FIFO of (a, b) operand pairs. Writes while
// full are dropped and latched in a sticky overflow flag.
module operand_pair_fifo #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_pair_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(DEPTH);

  if (ADDR_W != $clog2(DEPTH) || DEPTH < 2) begin : g_bad_param
    $error("operand_pair_fifo: ADDR_W must equal log2(DEPTH)");
  end

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic               r_overflow;
  logic [7:0]         r_pop_total;

  logic               w_full;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic [2*WIDTH-1:0] w_head;

  assign w_full  = (r_count == L_FULL);
  assign w_valid = (r_count != '0);
  // Full blocks the write even when a pop frees a slot this cycle.
  assign w_push  = bus.in_valid && !w_full;
  assign w_pop   = w_valid && bus.out_ready;
  assign w_head  = r_mem[r_rd_ptr];

  // Pointers, occupancy, overflow and pop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_pop_total <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
        r_pop_total <= r_pop_total + 8'd1;
      end
      if (bus.in_valid && w_full) r_overflow <= 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pair storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_a, bus.in_b};
  end

  assign bus.out_valid = w_valid;
  assign bus.out_a     = w_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
  assign bus.out_b     = w_valid ? w_head[WIDTH-1:0] : '0;
  assign bus.in_ready  = !w_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.pop_total = r_pop_total;

endmodule

// File: tb/tb_operand_pair_fifo.sv
// Scoreboard bench for operand_pair_fifo: default 4x4 instance plus
// an 8-bit, 8-deep override instance.
module tb_operand_pair_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_pair_fifo_if #(.WIDTH(4), .ADDR_W(2)) bus ();
  operand_pair_fifo_if #(.WIDTH(8), .ADDR_W(3)) bus8 ();

  operand_pair_fifo #(.WIDTH(4), .DEPTH(4), .ADDR_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  operand_pair_fifo #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] q[$];
  int         m_count;
  logic       m_ovf;
  logic [7:0] m_pops;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_pops  = '0;
  endtask

  task automatic check_state();
    logic [7:0] e_head;
    e_head = (q.size() != 0) ? q[0] : 8'h00;
    chk("count", 32'(bus.count), 32'(m_count));
    chk("cnt_le_depth", 32'(bus.count <= 3'd4), 32'd1);
    chk("out_valid", 32'(bus.out_valid), 32'(m_count != 0));
    chk("valid_nz", 32'(!bus.out_valid || bus.count != 0), 32'd1);
    chk("in_ready", 32'(bus.in_ready), 32'(m_count != 4));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("pop_total", 32'(bus.pop_total), 32'(m_pops));
    chk("head", 32'({bus.out_a, bus.out_b}), 32'(e_head));
    chk("ptrs", 32'(2'(u_dut.r_wr_ptr - u_dut.r_rd_ptr)),
        32'(m_count % 4));
  endtask

  task automatic step(input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic rdy);
    logic       p_push;
    logic       p_pop;
    logic [7:0] e;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = rdy;
    p_pop  = (m_count != 0) && rdy;
    p_push = v && (m_count < 4);
    if (p_pop) begin
      e = q.pop_front();
      chk("pop_data", 32'({bus.out_a, bus.out_b}), 32'(e));
      m_pops = m_pops + 8'd1;
    end
    if (p_push) q.push_back({a, b});
    if (v && !p_push) m_ovf = 1'b1;
    m_count = m_count + int'(p_push) - int'(p_pop);
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_a      = '0;
    bus8.in_b      = '0;
    bus8.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    rst = 1'b0;
    repeat (3) step(1'b0, 4'd0, 4'd0, 1'b0);

    step(1'b1, 4'd3, 4'd5, 1'b0);
    step(1'b1, 4'd7, 4'd9, 1'b0);
    step(1'b1, 4'd1, 4'd2, 1'b0);
    step(1'b1, 4'd15, 4'd0, 1'b0);
    step(1'b1, 4'd6, 4'd6, 1'b1);
    repeat (4) step(1'b0, 4'd0, 4'd0, 1'b1);

    step(1'b1, 4'd1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 4'(i + 3), 4'(15 - i), 1'b1);
    repeat (2) step(1'b0, 4'd0, 4'd0, 1'b1);

    step(1'b1, 4'd4, 4'd4, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_a     = (i == 0) ? 8'hA5 : 8'(i);
      bus8.in_b     = (i == 0) ? 8'h3C : 8'(i + 16);
      @(posedge clk);
      #1;
      chk("w8_count", 32'(bus8.count), 32'(i + 1));
      chk("w8_ready", 32'(bus8.in_ready), 32'(i < 7));
      chk("w8_a", 32'(bus8.out_a), 32'h A5);
      chk("w8_b", 32'(bus8.out_b), 32'h3C);
    end
    bus8.in_a = 8'hFF;
    @(posedge clk);
    #1;
    chk("w8_ovf", 32'(bus8.overflow), 32'd1);
    chk("w8_full", 32'(bus8.count), 32'd8);
    bus8.in_valid = 1'b0;

    step(1'b1, 4'd8, 4'd8, 1'b0);
    step(1'b1, 4'd9, 4'd8, 1'b0);
    step(1'b1, 4'd10, 4'd8, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state();
    chk("w8_rst_count", 32'(bus8.count), 32'd0);
    chk("w8_rst_ovf", 32'(bus8.overflow), 32'd0);
    #2;
    rst = 1'b0;
    step(1'b1, 4'd9, 4'd10, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
